// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt aggregator.
//   irq_state_e : irq request FSM states
//   ADDR_*      : register-port address map
package interrupt_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } irq_state_e;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PENDING = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_SET     = 2'd3;

endpackage

// File: rtl/irq_src_detect.sv
// Per-source event detector: rising-edge or level, selected per bit.
//   clk, rst  : clock, synchronous active-high reset
//   src       : raw source lines (synchronous to clk)
//   src_evt_c : combinational event vector for this cycle
module irq_src_detect #(
    parameter int unsigned N_SRC    = 8,
    parameter logic [7:0]  EDGE_SEL = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] src_evt_c
);

    localparam logic [N_SRC-1:0] EDGE_MASK = EDGE_SEL[N_SRC-1:0];

    logic [N_SRC-1:0] src_q;

    // Previous-cycle copy of the sources for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src;
        end
    end

    // Edge bits fire on 0->1, level bits fire every cycle the line is high
    assign src_evt_c = (src & ~src_q & EDGE_MASK) | (src & ~EDGE_MASK);

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt aggregator: sticky pending bits, per-source enable, registered
// status, level irq with a guaranteed low gap after every deassertion.
//   clk, rst : clock, synchronous active-high reset
//   src      : interrupt source lines
//   wr_en, rd_en, addr, wdata : register port (STATUS/PENDING/ENABLE/SET)
//   rdata    : read data, valid the cycle after rd_en
//   irq      : level interrupt request
//   status   : pending & enable, registered
module interrupt_ctrl
    import interrupt_pkg::*;
#(
    parameter int unsigned N_SRC    = 8,
    parameter int unsigned HOLDOFF  = 4,
    parameter logic [7:0]  EDGE_SEL = 8'hFF,
    parameter logic [7:0]  RESET_EN = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq,
    output logic [DATA_W-1:0] status
);

    localparam int unsigned CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [N_SRC-1:0]  src_evt_c;
    logic [N_SRC-1:0]  pending, pending_d;
    logic [N_SRC-1:0]  enable, enable_d;
    logic [N_SRC-1:0]  set_wr, clr_wr;
    logic [DATA_W-1:0] rdata_d;
    irq_state_e        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              irq_d;

    irq_src_detect #(
        .N_SRC    (N_SRC),
        .EDGE_SEL (EDGE_SEL)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .src_evt_c (src_evt_c)
    );

    // Register-port updates; set terms are OR'd after the clear so set wins
    always_comb begin
        set_wr    = (wr_en && addr == ADDR_SET)     ? wdata[N_SRC-1:0] : '0;
        clr_wr    = (wr_en && addr == ADDR_PENDING) ? wdata[N_SRC-1:0] : '0;
        enable_d  = (wr_en && addr == ADDR_ENABLE)  ? wdata[N_SRC-1:0] : enable;
        pending_d = src_evt_c | set_wr | (pending & ~clr_wr);
    end

    // Read mux samples pre-write register values
    always_comb begin
        rdata_d = '0;
        case (addr)
            ADDR_STATUS:  rdata_d = status;
            ADDR_PENDING: rdata_d = DATA_W'(pending);
            ADDR_ENABLE:  rdata_d = DATA_W'(enable);
            default:      rdata_d = '0;
        endcase
    end

    // Pending/enable/status/read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            enable  <= RESET_EN[N_SRC-1:0];
            status  <= '0;
            rdata   <= '0;
        end else begin
            pending <= pending_d;
            enable  <= enable_d;
            status  <= DATA_W'(pending_d & enable_d);
            if (rd_en) begin
                rdata <= rdata_d;
            end
        end
    end

    // FSM state register, holdoff counter and registered irq
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            irq   <= irq_d;
        end
    end

    // Next-state logic; GAP counts HOLDOFF cycles, IDLE adds one more low cycle
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (|status) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (status == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(HOLDOFF - 1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode, registered alongside the state
    always_comb begin
        irq_d = 1'b0;
        if (state_d == ASSERT) begin
            irq_d = 1'b1;
        end
    end

endmodule
